// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA timing generator.
// Defaults describe 800x600@72 Hz at a 50 MHz pixel rate from a 100 MHz clock.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 11;

    localparam int unsigned DEF_CLK_DIV   = 2;
    localparam int unsigned DEF_H_VISIBLE = 800;
    localparam int unsigned DEF_H_FRONT   = 56;
    localparam int unsigned DEF_H_SYNC    = 120;
    localparam int unsigned DEF_H_BACK    = 64;
    localparam int unsigned DEF_V_VISIBLE = 600;
    localparam int unsigned DEF_V_FRONT   = 37;
    localparam int unsigned DEF_V_SYNC    = 6;
    localparam int unsigned DEF_V_BACK    = 23;

    localparam int unsigned H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb444_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Client-facing bundle: coordinates/blanking out to the colour client, RGB back.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    coord_t     CurrentX;
    coord_t     CurrentY;
    logic       HBlank;
    logic       VBlank;
    logic       PixelTick;
    logic       FrameStart;
    logic [3:0] RED_IN;
    logic [3:0] GREEN_IN;
    logic [3:0] BLUE_IN;

    modport master (
        output CurrentX, CurrentY, HBlank, VBlank, PixelTick, FrameStart,
        input  RED_IN, GREEN_IN, BLUE_IN
    );

    modport slave (
        input  CurrentX, CurrentY, HBlank, VBlank, PixelTick, FrameStart,
        output RED_IN, GREEN_IN, BLUE_IN
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One display axis: position counter with registered blank and sync decode.
// blank/sync_raw are computed from the next count so they always match count.
module vga_axis_counter import vga_timing_pkg::*; #(
    parameter int unsigned VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned FRONT   = DEF_H_FRONT,
    parameter int unsigned SYNC    = DEF_H_SYNC,
    parameter int unsigned BACK    = DEF_H_BACK
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   enable,
    output coord_t count,
    output logic   blank,
    output logic   sync_raw,
    output logic   wrap_c
);

    localparam int unsigned TOTAL      = VISIBLE + FRONT + SYNC + BACK;
    localparam coord_t      LAST       = COORD_W'(TOTAL - 1);
    localparam coord_t      VIS_END    = COORD_W'(VISIBLE);
    localparam coord_t      SYNC_START = COORD_W'(VISIBLE + FRONT);
    localparam coord_t      SYNC_END   = COORD_W'(VISIBLE + FRONT + SYNC);

    coord_t count_q, count_d;
    logic   blank_q, blank_d;
    logic   sync_q, sync_d;

    always_comb begin
        count_d = count_q;
        wrap_c  = enable && (count_q == LAST);
        if (enable) begin
            count_d = wrap_c ? '0 : count_q + COORD_W'(1);
        end
        blank_d = (count_d >= VIS_END);
        sync_d  = (count_d >= SYNC_START) && (count_d < SYNC_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            blank_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            blank_q <= blank_d;
            sync_q  <= sync_d;
        end
    end

    assign count    = count_q;
    assign blank    = blank_q;
    assign sync_raw = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel prescaler, H/V counters, frame pulse and the
// registered pin stage that blanks client RGB and aligns sync with it.
module vga_timing_gen import vga_timing_pkg::*; #(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter bit          SYNC_POL  = 1'b1
) (
    input  logic              CLK_100MHz,
    input  logic              RESET,
    vga_timing_gen_if.master  cli,
    output logic [3:0]        VGA_RED,
    output logic [3:0]        VGA_GREEN,
    output logic [3:0]        VGA_BLUE,
    output logic              VGA_HS,
    output logic              VGA_VS
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             frame_start_q, frame_start_d;
    rgb444_t          rgb_q, rgb_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;

    coord_t h_count, v_count;
    logic   h_blank, v_blank, h_sync_raw, v_sync_raw, h_wrap_c, v_wrap_c;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE), .FRONT (H_FRONT), .SYNC (H_SYNC), .BACK (H_BACK)
    ) u_h_counter (
        .clk      (CLK_100MHz),
        .rst      (RESET),
        .enable   (tick_q),
        .count    (h_count),
        .blank    (h_blank),
        .sync_raw (h_sync_raw),
        .wrap_c   (h_wrap_c)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE), .FRONT (V_FRONT), .SYNC (V_SYNC), .BACK (V_BACK)
    ) u_v_counter (
        .clk      (CLK_100MHz),
        .rst      (RESET),
        .enable   (h_wrap_c && tick_q),
        .count    (v_count),
        .blank    (v_blank),
        .sync_raw (v_sync_raw),
        .wrap_c   (v_wrap_c)
    );

    // Flag the tick of pixel (0,0); if the counters move this edge, (0,0) is next only on a full wrap.
    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        tick_d = (div_d == DIV_LAST);
        if (tick_q) begin
            frame_start_d = tick_d && h_wrap_c && v_wrap_c;
        end else begin
            frame_start_d = tick_d && (h_count == '0) && (v_count == '0);
        end

        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (tick_q) begin
            rgb_d = (h_blank || v_blank) ? '0 : {cli.RED_IN, cli.GREEN_IN, cli.BLUE_IN};
            hs_d  = h_sync_raw ? SYNC_POL : !SYNC_POL;
            vs_d  = v_sync_raw ? SYNC_POL : !SYNC_POL;
        end
    end

    always_ff @(posedge CLK_100MHz) begin
        if (RESET) begin
            div_q         <= '0;
            tick_q        <= 1'b0;
            frame_start_q <= 1'b0;
            rgb_q         <= '0;
            hs_q          <= !SYNC_POL;
            vs_q          <= !SYNC_POL;
        end else begin
            div_q         <= div_d;
            tick_q        <= tick_d;
            frame_start_q <= frame_start_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
        end
    end

    assign cli.CurrentX   = h_count;
    assign cli.CurrentY   = v_count;
    assign cli.HBlank     = h_blank;
    assign cli.VBlank     = v_blank;
    assign cli.PixelTick  = tick_q;
    assign cli.FrameStart = frame_start_q;

    assign VGA_RED   = rgb_q.red;
    assign VGA_GREEN = rgb_q.green;
    assign VGA_BLUE  = rgb_q.blue;
    assign VGA_HS    = hs_q;
    assign VGA_VS    = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced geometry so whole frames fit in a short run.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int unsigned D     = 2;
    localparam int unsigned H_VIS = 16, H_FP = 3, H_SY = 4, H_BP = 5;
    localparam int unsigned V_VIS = 10, V_FP = 2, V_SY = 3, V_BP = 2;
    localparam bit          POL   = 1'b1;
    localparam int unsigned HT    = H_VIS + H_FP + H_SY + H_BP;
    localparam int unsigned VT    = V_VIS + V_FP + V_SY + V_BP;
    localparam int unsigned FRAME = HT * VT * D;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic hb, vb, tick, fs;
    } st_t;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } pin_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs;

    vga_timing_gen_if cli ();

    vga_timing_gen #(
        .CLK_DIV (D),
        .H_VISIBLE (H_VIS), .H_FRONT (H_FP), .H_SYNC (H_SY), .H_BACK (H_BP),
        .V_VISIBLE (V_VIS), .V_FRONT (V_FP), .V_SYNC (V_SY), .V_BACK (V_BP),
        .SYNC_POL (POL)
    ) dut (
        .CLK_100MHz (clk),
        .RESET      (rst),
        .cli        (cli),
        .VGA_RED    (vga_r),
        .VGA_GREEN  (vga_g),
        .VGA_BLUE   (vga_b),
        .VGA_HS     (vga_hs),
        .VGA_VS     (vga_vs)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    st_t  st_q[$];
    pin_t pin_q[$];
    int   cyc      = 0;
    bit   model_on = 1'b0;
    bit   rst_edge = 1'b0;
    int   mode     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: cycle c after reset belongs to pixel c/D in raster order.
    function automatic st_t model_state(input int c);
        st_t s;
        int  n, x, y;
        n      = c / int'(D);
        x      = n % int'(HT);
        y      = (n / int'(HT)) % int'(VT);
        s.x    = COORD_W'(x);
        s.y    = COORD_W'(y);
        s.hb   = (x >= int'(H_VIS));
        s.vb   = (y >= int'(V_VIS));
        s.tick = ((c % int'(D)) == int'(D) - 1);
        s.fs   = s.tick && (x == 0) && (y == 0);
        return s;
    endfunction

    function automatic logic sync_level(input int p, input int lo, input int w);
        return (p >= lo && p < lo + w) ? POL : !POL;
    endfunction

    // Model clock: one expected state per edge.
    always @(posedge clk) begin
        if (rst) begin
            cyc      = 0;
            model_on = 1'b1;
            rst_edge = 1'b1;
        end else begin
            cyc++;
            rst_edge = 1'b0;
        end
        if (model_on) st_q.push_back(model_state(cyc));
    end

    // Colour client; on the sampling cycle of each pixel the expected pin word is queued.
    logic [11:0] drv_v, drv_e;
    st_t         drv_s;
    always @(negedge clk) begin
        drv_s = model_state(cyc);
        case (mode)
            0:       drv_v = 12'($urandom);
            1:       drv_v = 12'hfff;
            default: drv_v = {cli.CurrentX[3:0], cli.CurrentY[3:0], 4'h5};
        endcase
        drv_e = (mode >= 2) ? {drv_s.x[3:0], drv_s.y[3:0], 4'h5} : drv_v;
        {cli.RED_IN, cli.GREEN_IN, cli.BLUE_IN} = drv_v;
        if (model_on && drv_s.tick) begin
            pin_q.push_back({(drv_s.hb || drv_s.vb) ? 12'h000 : drv_e,
                             sync_level(int'(drv_s.x), int'(H_VIS + H_FP), int'(H_SY)),
                             sync_level(int'(drv_s.y), int'(V_VIS + V_FP), int'(V_SY))});
        end
    end

    st_t  mon_exp, mon_act;
    pin_t last_pin, act_pin;
    bit   tick_prev = 1'b0;
    logic hs_prev = !POL, vs_prev = !POL;
    int   mon_cyc = 0, last_fs = -1, hs_start = -1, vs_start = -1;

    always @(posedge clk) begin
        #1;
        mon_cyc++;
        if (model_on) begin
            mon_exp = st_q.pop_front();
            mon_act = {cli.CurrentX, cli.CurrentY, cli.HBlank, cli.VBlank, cli.PixelTick, cli.FrameStart};
            check("state{x,y,hb,vb,tick,fs}", 64'(mon_act), 64'(mon_exp));

            if (rst_edge) begin
                pin_q.delete();
                last_pin = {12'h000, !POL, !POL};
                last_fs  = -1;
                hs_start = -1;
                vs_start = -1;
            end else if (tick_prev) begin
                if (pin_q.size() == 0) check("pin_queue_underflow", 64'(1), 64'(0));
                else last_pin = pin_q.pop_front();
            end
            act_pin = {vga_r, vga_g, vga_b, vga_hs, vga_vs};
            check("pins{rgb,hs,vs}", 64'(act_pin), 64'(last_pin));

            if (!rst_edge) begin
                if (cli.FrameStart) begin
                    if (last_fs >= 0) check("frame_period", 64'(mon_cyc - last_fs), 64'(FRAME));
                    last_fs = mon_cyc;
                end
                if (vga_hs == POL && hs_prev != POL) hs_start = mon_cyc;
                if (vga_hs != POL && hs_prev == POL && hs_start >= 0)
                    check("hs_width", 64'(mon_cyc - hs_start), 64'(H_SY * D));
                if (vga_vs == POL && vs_prev != POL) vs_start = mon_cyc;
                if (vga_vs != POL && vs_prev == POL && vs_start >= 0)
                    check("vs_width", 64'(mon_cyc - vs_start), 64'(V_SY * HT * D));
            end
            hs_prev   = vga_hs;
            vs_prev   = vga_vs;
            tick_prev = cli.PixelTick;
        end
    end

    initial begin
        mode = 0;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (FRAME + 300) @(negedge clk);

        // Mid-frame reset held for three cycles.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        mode = 1;
        repeat (FRAME + 100) @(negedge clk);
        mode = 2;
        repeat (FRAME + 100) @(negedge clk);

        mode = 0;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(400, 5)) @(negedge clk);
            rst = 1'b1;
            repeat ($urandom_range(3, 1)) @(negedge clk);
            rst = 1'b0;
        end
        repeat (FRAME + 50) @(negedge clk);

        @(posedge clk);
        #2;
        check("pin_queue_drained", 64'(pin_q.size()), 64'(0));
        check("state_queue_drained", 64'(st_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Timing generator and pixel output stage of the VGA path. Produces the pixel coordinates and blanking flags that the colour client consumes, and takes the client's combinational RGB back. Registers that RGB to the VGA pins together with delay-matched horizontal and vertical sync. Default geometry is 800x600@72 Hz with a 50 MHz pixel rate derived from the 100 MHz system clock.

## Interface

Parameters:
- CLK_DIV, 2, system clocks per pixel
- H_VISIBLE, 800, visible pixels per line
- H_FRONT, 56, horizontal front porch in pixels
- H_SYNC, 120, horizontal sync width in pixels
- H_BACK, 64, horizontal back porch in pixels
- V_VISIBLE, 600, visible lines per frame
- V_FRONT, 37, vertical front porch in lines
- V_SYNC, 6, vertical sync width in lines
- V_BACK, 23, vertical back porch in lines
- SYNC_POL, 1, active level of VGA_HS and VGA_VS

Ports:
- CLK_100MHz  in  1  system clock; the only clock
- RESET  in  1  synchronous, active-high reset
- RED_IN, GREEN_IN, BLUE_IN  in  4 each  client colour for the current (CurrentX, CurrentY)
- CurrentX  out  11  horizontal pixel counter, 0..H_TOTAL-1
- CurrentY  out  11  vertical line counter, 0..V_TOTAL-1
- HBlank  out  1  high when CurrentX >= H_VISIBLE
- VBlank  out  1  high when CurrentY >= V_VISIBLE
- PixelTick  out  1  one-cycle pixel enable
- FrameStart  out  1  one-cycle pulse at pixel (0,0)
- VGA_RED, VGA_GREEN, VGA_BLUE  out  4 each  registered pin colour
- VGA_HS, VGA_VS  out  1 each  registered sync

## Operation

Totals:
- H_TOTAL = sum of the four H parameters, 1040 by default.
- V_TOTAL = sum of the four V parameters, 666 by default.

Pixel prescaler:
- div counter runs 0..CLK_DIV-1 and wraps.
- PixelTick = (div == CLK_DIV-1).

Counters (advance only on a clock edge where PixelTick is high):
- CurrentX increments; at H_TOTAL-1 it wraps to 0 and CurrentY advances.
- CurrentY increments on each horizontal wrap; at V_TOTAL-1 it wraps to 0.
- HBlank and VBlank are registered and always consistent with the CurrentX/CurrentY values they accompany.

Sync decode:
- h_sync_raw is active for CurrentX in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. 856..975 by default.
- v_sync_raw is active for CurrentY in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), i.e. 637..642 by default.

Output stage (updates on PixelTick edges):
- Pin RGB captures {RED_IN, GREEN_IN, BLUE_IN}, or 12'h000 if HBlank || VBlank, regardless of what the client drives.
- VGA_HS and VGA_VS capture the sync decode of the same pixel. Sync is therefore aligned with the RGB it accompanies.

FrameStart = PixelTick && CurrentX == 0 && CurrentY == 0.

Reset state (synchronous; values apply on the edge after RESET is sampled high, including mid-line or mid-frame):
- div = 0; CurrentX = CurrentY = 0
- HBlank = VBlank = 0
- PixelTick = FrameStart = 0
- pin RGB = 0
- VGA_HS = VGA_VS = !SYNC_POL

## Timing

- Each (CurrentX, CurrentY) is held for exactly CLK_DIV cycles. The client's combinational RGB is sampled on the final edge of that window.
- The first PixelTick after RESET falls is in the cycle where div == CLK_DIV-1: the 2nd cycle by default.
- Pin latency: pins reflect pixel (X,Y) starting one edge after that pixel's last PixelTick cycle. They hold for CLK_DIV cycles, i.e. one pixel period behind the counters.
- Line period: H_TOTAL*CLK_DIV = 2080 clocks.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV = 1,385,280 clocks.
- FrameStart repeats once per frame period; no counter values are skipped or repeated across wraps.
- Simultaneous horizontal and vertical wrap at (1039, 665): next pixel is (0,0) and FrameStart fires on it.
- RESET held high: PixelTick stays 0 and the counters stay frozen at 0.

## Structure

- Package vga_timing_pkg holds:
  - default 800x600@72 timing constants
  - derived H_TOTAL/V_TOTAL
  - the 11-bit coordinate width
  - a 12-bit rgb444 typedef
- Sub-module vga_axis_counter is instantiated once for H and once for V:
  - parameters: visible, front, sync, back
  - inputs: enable, clock, reset
  - outputs: count, blank, sync_raw, wrap
  - the H instance is enabled by PixelTick; the V instance by H wrap && PixelTick.
- Prescaler, FrameStart, and the output register stage live in vga_timing_gen.

## Test plan

- Reset: assert RESET for 3 cycles mid-frame (X=400, Y=300) -> next edge shows X=Y=0, pin RGB 0, HS=VS=0 (SYNC_POL=1); first PixelTick in 2nd cycle after release.
- Horizontal wrap: run to X=1039, Y=10 -> following pixel X=0, Y=11; HBlank high over X 800..1039 and low at X=0.
- HSYNC alignment: HS pin rises one pixel period after X reaches 856 and falls one pixel period after X reaches 976 (120 pixels = 240 clocks wide).
- Blank forcing: client drives 12'hfff constantly -> pins 12'hfff for visible pixels, 12'h000 for every pixel with X>=800 or Y>=600.
- Frame cadence: count clocks between consecutive FrameStart pulses -> exactly 1,385,280; VS active for 6 lines (12,480 clocks) starting at Y=637.
- Data path: client drives RGB = {CurrentX[3:0], CurrentY[3:0], 4'h5} -> every visible pin sample equals the expected value of the pixel one period earlier.
